// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// The master view belongs to the loader, the slave view to the stream source / memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_wdata;
    logic              cpu_ready;
    logic              load_err;
    logic [ADDR_W-1:0] word_cnt;

    modport master (
        input  in_valid, in_data,
        output in_ready, im_we, im_addr, im_wdata, cpu_ready, load_err, word_cnt
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, im_we, im_addr, im_wdata, cpu_ready, load_err, word_cnt
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: receives a LEN / 2N data bytes / CHK frame, writes 16-bit words from address 0,
// and releases the processor only when the XOR checksum of the data bytes matches.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    imem_loader_if.master       bus
);

    typedef enum logic [2:0] {
        S_LEN,
        S_HI,
        S_LO,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_n;
    logic              in_ready_c;
    logic              xfer;
    logic              last_word;

    logic [7:0]        len_r;
    logic [7:0]        chk_r;
    logic [7:0]        hi_p0;
    logic              we_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] wdata_p1;
    logic [ADDR_W-1:0] cnt_r;

    function automatic logic [DATA_W-1:0] pack_word(input logic [7:0] hi, input logic [7:0] lo);
        return DATA_W'({hi, lo});
    endfunction

    // Acceptance depends on state only, so the source may wait on in_ready before raising in_valid.
    assign in_ready_c = (state == S_LEN) || (state == S_HI) ||
                        (state == S_LO)  || (state == S_CHK);
    assign xfer       = bus.in_valid && in_ready_c;
    assign last_word  = (cnt_r + ADDR_W'(1)) == ADDR_W'(len_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LEN;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_LEN:   if (xfer) state_n = (bus.in_data == 8'd0) ? S_CHK : S_HI;
            S_HI:    if (xfer) state_n = S_LO;
            S_LO:    if (xfer) state_n = last_word ? S_CHK : S_HI;
            S_CHK:   if (xfer) state_n = (bus.in_data == chk_r) ? S_DONE : S_ERR;
            default: state_n = state;
        endcase
    end

    // p0: byte capture and running checksum; p1: one-cycle memory write of the assembled word
    always_ff @(posedge clk) begin
        if (rst) begin
            len_r    <= '0;
            chk_r    <= '0;
            hi_p0    <= '0;
            we_p1    <= 1'b0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
            cnt_r    <= '0;
        end else begin
            we_p1 <= 1'b0;
            if (xfer) begin
                case (state)
                    S_LEN: begin
                        len_r <= bus.in_data;
                        chk_r <= '0;
                    end
                    S_HI: begin
                        hi_p0 <= bus.in_data;
                        chk_r <= chk_r ^ bus.in_data;
                    end
                    S_LO: begin
                        chk_r    <= chk_r ^ bus.in_data;
                        we_p1    <= 1'b1;
                        addr_p1  <= cnt_r;
                        wdata_p1 <= pack_word(hi_p0, bus.in_data);
                        cnt_r    <= cnt_r + ADDR_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.im_we     = we_p1;
    assign bus.im_addr   = addr_p1;
    assign bus.im_wdata  = wdata_p1;
    assign bus.word_cnt  = cnt_r;
    assign bus.cpu_ready = (state == S_DONE);
    assign bus.load_err  = (state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as frames are sent and
// matched against each im_we pulse; frame outcome and reset behaviour are checked directly.
module tb_imem_loader;

    logic clk;
    logic rst;

    imem_loader_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    imem_loader #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] exp_q [$];
    logic [23:0] mon_e;
    logic [15:0] frm [0:15];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.im_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", 32'(bus.im_we), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("we_addr", 32'(bus.im_addr), 32'(mon_e[23:16]));
                check("we_data", 32'(bus.im_wdata), 32'(mon_e[15:0]));
            end
        end
    end

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready",  32'(bus.in_ready), 1);
        check("rst_im_we",     32'(bus.im_we), 0);
        check("rst_im_addr",   32'(bus.im_addr), 0);
        check("rst_im_wdata",  32'(bus.im_wdata), 0);
        check("rst_cpu_ready", 32'(bus.cpu_ready), 0);
        check("rst_load_err",  32'(bus.load_err), 0);
        check("rst_word_cnt",  32'(bus.word_cnt), 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        if (gaps) check("rdy_held", 32'(bus.in_ready), 1);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("xfer_timeout", 0, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [7:0] flip, input bit gaps);
        logic [7:0] c;
        c = 8'h00;
        send_byte(8'(n), gaps);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({8'(i), frm[i]});
            c = c ^ frm[i][15:8] ^ frm[i][7:0];
            send_byte(frm[i][15:8], gaps);
            send_byte(frm[i][7:0], gaps);
        end
        check("ready_early", 32'(bus.cpu_ready), 0);
        send_byte(c ^ flip, gaps);
        check("cpu_ready",  32'(bus.cpu_ready), (flip == 8'h00) ? 1 : 0);
        check("load_err",   32'(bus.load_err),  (flip == 8'h00) ? 0 : 1);
        check("in_ready_end", 32'(bus.in_ready), 0);
        check("word_cnt",   32'(bus.word_cnt), 32'(n));
        check("writes_left", 32'(exp_q.size()), 0);
        repeat (3) @(negedge clk);
        check("cpu_ready_hold", 32'(bus.cpu_ready), (flip == 8'h00) ? 1 : 0);
        check("load_err_hold",  32'(bus.load_err),  (flip == 8'h00) ? 0 : 1);
    endtask

    task automatic load_two();
        frm[0] = 16'h3200;
        frm[1] = 16'h3107;
    endtask

    task automatic load_prog();
        frm[0]  = 16'h3200; frm[1]  = 16'h3400; frm[2]  = 16'h3107; frm[3]  = 16'h3301;
        frm[4]  = 16'h2512; frm[5]  = 16'h1502; frm[6]  = 16'h0202; frm[7]  = 16'h4613;
        frm[8]  = 16'h1603; frm[9]  = 16'h0103; frm[10] = 16'h5102; frm[11] = 16'h54F9;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        @(negedge clk);
        do_reset();

        load_two();
        send_frame(2, 8'h00, 1'b0);
        do_reset();

        load_prog();
        send_frame(12, 8'h00, 1'b0);
        do_reset();

        load_two();
        send_frame(2, 8'h01, 1'b0);
        do_reset();

        send_frame(0, 8'h00, 1'b0);
        do_reset();
        send_frame(0, 8'h01, 1'b0);
        do_reset();

        load_two();
        send_frame(2, 8'h00, 1'b1);
        do_reset();

        // Partial word, then reset coinciding with an offered LO byte; nothing may be written.
        send_byte(8'h02, 1'b0);
        send_byte(8'h32, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("midrst_word_cnt", 32'(bus.word_cnt), 0);
        check("midrst_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        check("midrst_no_we", 32'(bus.im_we), 0);
        load_two();
        send_frame(2, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the single-cycle processor top.
- Accepts a byte stream over a valid/ready handshake and assembles 16-bit instruction words.
- Writes the words sequentially into instruction memory from address 0, then checks a frame checksum.
- On a good checksum it raises the processor's `ready` start signal, which replaces bench backdoor loading of InstructionMem.

Parameters:
- ADDR_W, 8, instruction-memory address width; must be >= 8 so a full 255-word frame fits.
- DATA_W, 16, instruction word width; fixed at 16 (two bytes per word).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte; a transfer occurs when in_valid && in_ready at a clk edge.
- im_we  output  1  instruction-memory write enable, one-cycle pulse.
- im_addr  output  ADDR_W  instruction-memory write address.
- im_wdata  output  DATA_W  instruction word to write.
- cpu_ready  output  1  processor start, connected to the top's `ready` input.
- load_err  output  1  checksum mismatch, sticky.
- word_cnt  output  ADDR_W  number of words written so far.

Behaviour:
- Frame format: LEN byte N (0..255), then 2N data bytes (high byte first per word), then a CHK byte.
  - CHK is the XOR of all 2N data bytes; LEN is excluded from CHK.
- FSM states:
  - S_LEN: on transfer, latch N and clear the running checksum. If N == 0, go to S_CHK; else go to S_HI.
  - S_HI: on transfer, latch the high byte, XOR it into the checksum, go to S_LO.
  - S_LO: on transfer, XOR the byte into the checksum and form word {hi, byte}.
    - Next cycle: im_we = 1, im_addr = word_cnt, im_wdata = word; word_cnt increments in that same cycle.
    - If this was word N, go to S_CHK; else go to S_HI.
  - S_CHK: on transfer, compare the byte to the running checksum. Match: go to S_DONE; mismatch: go to S_ERR.
  - S_DONE: cpu_ready = 1 from the cycle after the CHK transfer, held until rst. in_ready = 0.
  - S_ERR: load_err = 1 from the cycle after the CHK transfer, held until rst. cpu_ready stays 0. in_ready = 0.
- in_ready = 1 in S_LEN, S_HI, S_LO and S_CHK. It is combinational from state only and never depends on in_valid.
- No transfer (in_valid = 0) means the state holds; bubbles are allowed between any two bytes.
- im_we is registered, asserted for exactly one cycle per word, never asserted in S_DONE/S_ERR, and never asserted for the CHK byte.
- im_addr and im_wdata are don't-care when im_we = 0, but must be stable during the im_we cycle.
- The last word's write occurs one cycle after its LO transfer, which is before any CHK transfer can complete. All writes therefore precede cpu_ready.
- Words are written even if the checksum later fails; load_err blocks the start, so no rollback is needed.
- Reset values: state = S_LEN; in_ready = 1 in the cycle after reset; im_we = 0, im_addr = 0, im_wdata = 0, cpu_ready = 0, load_err = 0, word_cnt = 0, checksum = 0.
- rst asserted mid-frame: return to S_LEN next cycle, drop any partial word (no im_we), clear word_cnt and the checksum. rst has priority over a simultaneous transfer.
- rst while in S_DONE: cpu_ready deasserts the next cycle. This halts the processor start, and reloading is allowed.
- Counter widths: word_cnt has ADDR_W bits; the word index compare uses N zero-extended to ADDR_W. No wrap is possible for ADDR_W >= 8.

Test Plan:
- Two-word frame 02,32,00,31,07,CHK=04, continuous valid -> im_we pulses write addr0 = 0x3200 and addr1 = 0x3107; cpu_ready = 1 one cycle after the CHK transfer; load_err = 0; word_cnt = 2.
- Full 12-word sum-to-n program (0x3200, 0x3400, 0x3107, 0x3301, 0x2512, 0x1502, 0x0202, 0x4613, 0x1603, 0x0103, 0x5102, 0x54F9) with the correct CHK -> all 12 words are written, cpu_ready rises, and the processor's data memory DataMem[2] ends at 28.
- Same two-word frame with CHK = 05 -> both words are written, load_err = 1, cpu_ready stays 0, in_ready = 0 afterwards.
- LEN = 00 then CHK = 00 -> no im_we; cpu_ready = 1. A second run with LEN = 00, CHK = 01 -> load_err = 1.
- Random in_valid gaps (~50% duty) on the two-word frame -> identical writes and result; in_ready never drops before S_DONE.
- rst pulsed one cycle after the HI byte of word 1, then a full two-word frame is resent -> no write for the partial word, word_cnt restarts at 0, final memory and cpu_ready match the first scenario.
